// File: rtl/ext_bus_decoder_pkg.sv
// Shared types and defaults for the external bus decoder.
//   state_e        : decoder FSM states
//   *_BASE/*_MASK  : default address map (flash, RAM, two peripheral windows)
//   slot_lsb()     : bit offset of slot idx inside a packed per-slave vector
package ext_bus_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [31:0] FLASH_BASE   = 32'h0000_0000;
  localparam logic [31:0] FLASH_MASK   = 32'hFFFF_8000;
  localparam logic [31:0] RAM_BASE     = 32'h0000_8000;
  localparam logic [31:0] RAM_MASK     = 32'hFFFF_C000;
  localparam logic [31:0] PERIPH0_BASE = 32'h0001_0000;
  localparam logic [31:0] PERIPH0_MASK = 32'hFFFF_0000;
  localparam logic [31:0] PERIPH1_BASE = 32'h0002_0000;
  localparam logic [31:0] PERIPH1_MASK = 32'hFFFF_0000;

  function automatic int unsigned slot_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/ext_bus_decoder_if.sv
// External bus bundle between the core (single master), the decoder and the
// slave channels.
//   m_* : core-facing request/response
//   s_* : slave-facing chip select, request and per-slave responses
// Modports:
//   slave  : the decoder's view (it answers the core and drives the slaves)
//   master : the environment's view (core + slave models), the mirror image
interface ext_bus_decoder_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 512
);
  logic                         m_addr_valid;
  logic [ADDR_W-1:0]            m_addr;
  logic                         m_write_valid;
  logic [DATA_W-1:0]            m_wdata;
  logic                         m_ready;
  logic [DATA_W-1:0]            m_rdata;
  logic                         m_err;
  logic [NUM_SLAVES-1:0]        s_sel;
  logic                         s_addr_valid;
  logic [ADDR_W-1:0]            s_addr;
  logic                         s_write_valid;
  logic [DATA_W-1:0]            s_wdata;
  logic [NUM_SLAVES-1:0]        s_ready;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;

  modport slave (
    input  m_addr_valid, m_addr, m_write_valid, m_wdata,
    output m_ready, m_rdata, m_err,
    output s_sel, s_addr_valid, s_addr, s_write_valid, s_wdata,
    input  s_ready, s_rdata
  );

  modport master (
    output m_addr_valid, m_addr, m_write_valid, m_wdata,
    input  m_ready, m_rdata, m_err,
    input  s_sel, s_addr_valid, s_addr, s_write_valid, s_wdata,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/ext_bus_decoder_addr_match.sv
// Combinational address decode.
//   addr      in  : request address
//   sel_onehot out: one-hot select of the lowest-index slave whose window
//                   (addr & mask_i) == base_i matches; all-zero when unmapped
module ext_bus_decoder_addr_match
  import ext_bus_decoder_pkg::*;
#(
  parameter int                          NUM_SLAVES = 4,
  parameter int                          ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel_onehot
);

  logic [NUM_SLAVES-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = ((addr & SLAVE_MASK[slot_lsb(i, ADDR_W) +: ADDR_W]) ==
                SLAVE_BASE[slot_lsb(i, ADDR_W) +: ADDR_W]);
    end
  end

  // Walk from the top down so the lowest-index hit is the last one written.
  always_comb begin
    sel_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_bus_decoder.sv
// External bus decoder: registers one core request, chip-selects the matching
// slave, returns its response, and answers unmapped or stalled accesses with
// a one-cycle error pulse. One transaction outstanding at a time.
//   clk : bus clock
//   rst : asynchronous reset, active-low
//   bus : ext_bus_decoder_if.slave (core request/response + slave channels)
module ext_bus_decoder
  import ext_bus_decoder_pkg::*;
#(
  parameter int                          NUM_SLAVES = 4,
  parameter int                          ADDR_W     = 32,
  parameter int                          DATA_W     = 512,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {PERIPH1_BASE, PERIPH0_BASE, RAM_BASE, FLASH_BASE},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {PERIPH1_MASK, PERIPH0_MASK, RAM_MASK, FLASH_MASK},
  parameter int                          TIMEOUT    = 255,
  parameter int                          TO_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  ext_bus_decoder_if.slave bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [TO_W-1:0]       timer_q, timer_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  addr_valid_q, addr_valid_d;
  logic                  write_valid_q, write_valid_d;
  logic                  write_q, write_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic [NUM_SLAVES-1:0] hit_onehot;
  logic [DATA_W-1:0]     sel_rdata;

  ext_bus_decoder_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_addr_match (
    .addr       (bus.m_addr),
    .sel_onehot (hit_onehot)
  );

  // sel_q is one-hot, so OR-ing the gated slots yields the selected slot.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | bus.s_rdata[slot_lsb(i, DATA_W) +: DATA_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    sel_d         = sel_q;
    addr_valid_d  = addr_valid_q;
    write_valid_d = write_valid_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    ready_d       = 1'b0;
    err_d         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.m_addr_valid) begin
          addr_d  = bus.m_addr;
          wdata_d = bus.m_wdata;
          write_d = bus.m_write_valid;
          timer_d = '0;
          if (|hit_onehot) begin
            state_d       = ST_WAIT;
            sel_d         = hit_onehot;
            addr_valid_d  = 1'b1;
            write_valid_d = bus.m_write_valid;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ST_WAIT: begin
        // Only the selected slave may complete; its ready beats the timeout.
        if (|(bus.s_ready & sel_q)) begin
          state_d       = ST_DONE;
          ready_d       = 1'b1;
          rdata_d       = write_q ? '0 : sel_rdata;
          sel_d         = '0;
          addr_valid_d  = 1'b0;
          write_valid_d = 1'b0;
        end else if (timer_q == TO_LAST) begin
          state_d       = ST_ERR;
          err_d         = 1'b1;
          rdata_d       = '0;
          sel_d         = '0;
          addr_valid_d  = 1'b0;
          write_valid_d = 1'b0;
        end else if (timer_q != {TO_W{1'b1}}) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      sel_q         <= '0;
      addr_valid_q  <= 1'b0;
      write_valid_q <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      sel_q         <= sel_d;
      addr_valid_q  <= addr_valid_d;
      write_valid_q <= write_valid_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      ready_q       <= ready_d;
      err_q         <= err_d;
    end
  end

  assign bus.m_ready       = ready_q;
  assign bus.m_rdata       = rdata_q;
  assign bus.m_err         = err_q;
  assign bus.s_sel         = sel_q;
  assign bus.s_addr_valid  = addr_valid_q;
  assign bus.s_addr        = addr_q;
  assign bus.s_write_valid = write_valid_q;
  assign bus.s_wdata       = wdata_q;

endmodule
